// File: rtl/clk_ratio_meter.sv
// Measures period and high time of an asynchronous strobe in core clock cycles,
// with a lock flag for a stable period and a sticky timeout when edges stop.
module clk_ratio_meter #(
   parameter int WIDTH       = 15,
   parameter int LOCK_N      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sig_in,
   output logic [WIDTH-1:0] o_period,
   output logic [WIDTH-1:0] o_high_time,
   output logic             o_meas_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam int MW = $clog2(LOCK_N + 1);
   localparam logic [WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_N);

   typedef enum logic [1:0] {IDLE, SEEK, MEASURE} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic [WIDTH-1:0]       r_cnt;
   logic [WIDTH-1:0]       r_hcnt;
   logic [WIDTH-1:0]       r_period;
   logic [WIDTH-1:0]       r_high;
   logic                   r_mvld;
   logic                   r_locked;
   logic                   r_timeout;
   logic [MW-1:0]          r_match;

   logic                   w_s;
   logic                   w_rise;
   logic                   w_at_max;
   logic                   w_clear;
   logic                   w_start;
   logic                   w_capture;
   logic                   w_tmo;
   logic [MW-1:0]          w_match_nxt;

   // Fixed-depth chain: every edge sees the same latency, so periods stay exact.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
         r_s_d  <= w_s;
      end
   end

   assign w_s      = r_sync[SYNC_STAGES-1];
   assign w_rise   = w_s & ~r_s_d;
   assign w_at_max = (r_cnt == CNT_MAX);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_en) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = SEEK;
            SEEK:    if (w_rise) w_state_nxt = MEASURE;
            MEASURE: if (w_tmo)  w_state_nxt = SEEK;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_clear     = !i_en || (r_state == IDLE);
      w_start     = i_en && (r_state == SEEK) && w_rise;
      w_capture   = i_en && (r_state == MEASURE) && w_rise;
      // A rise in the last countable cycle is still a measurement.
      w_tmo       = i_en && (r_state != IDLE) && !w_rise && w_at_max;
      w_match_nxt = r_match;
      if (w_capture) begin
         if (r_match == '0 || r_cnt != r_period) w_match_nxt = MW'(1);
         else if (r_match != MATCH_FULL)         w_match_nxt = r_match + MW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_hcnt    <= '0;
         r_period  <= '0;
         r_high    <= '0;
         r_mvld    <= 1'b0;
         r_locked  <= 1'b0;
         r_timeout <= 1'b0;
         r_match   <= '0;
      end else begin
         r_mvld <= w_capture;
         if (w_clear) begin
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_match   <= '0;
         end else if (w_start || w_capture) begin
            r_cnt  <= WIDTH'(1);
            r_hcnt <= WIDTH'(1);
            if (w_capture) begin
               r_period <= r_cnt;
               r_high   <= r_hcnt;
               r_match  <= w_match_nxt;
               r_locked <= (w_match_nxt == MATCH_FULL);
            end
         end else if (w_tmo) begin
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_timeout <= 1'b1;
            r_locked  <= 1'b0;
            r_match   <= '0;
         end else begin
            r_cnt <= r_cnt + WIDTH'(1);
            if (r_state == MEASURE) r_hcnt <= r_hcnt + WIDTH'(w_s);
         end
      end
   end

   assign o_period     = r_period;
   assign o_high_time  = r_high;
   assign o_meas_valid = r_mvld;
   assign o_locked     = r_locked;
   assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed and randomized bench for clk_ratio_meter (WIDTH=6) against a timestamp model.
module tb_clk_ratio_meter;

   localparam int WIDTH  = 6;
   localparam int LOCK_N = 4;
   localparam int SYNC   = 2;
   localparam int MAXC   = (1 << WIDTH) - 1;
   localparam int HIST   = 8192;

   logic             clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_en = 1'b0;
   logic             i_sig_in = 1'b0;
   logic [WIDTH-1:0] o_period;
   logic [WIDTH-1:0] o_high_time;
   logic             o_meas_valid;
   logic             o_locked;
   logic             o_timeout;

   clk_ratio_meter #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .SYNC_STAGES(SYNC)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_sig_in(i_sig_in),
      .o_period(o_period), .o_high_time(o_high_time), .o_meas_valid(o_meas_valid),
      .o_locked(o_locked), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit sig_h [0:HIST-1];
   bit en_h  [0:HIST-1];

   // Expected outputs after the next clock edge; sig driven in cycle k is seen as a rise at edge k+3.
   int exp_period = 0, exp_high = 0;
   bit exp_mv = 0, exp_locked = 0, exp_timeout = 0;
   bit active = 0, have_ref = 0;
   int ref_e = 0, run = 0, last_p = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge(input int c, input bit r);
      int e;
      int h;
      bit rise;
      e = c + 1;
      exp_mv = 0;
      if (r) begin
         exp_period = 0; exp_high = 0; exp_locked = 0; exp_timeout = 0;
         active = 0; have_ref = 0; run = 0;
      end else if (!en_h[c]) begin
         active = 0; have_ref = 0; run = 0;
         exp_locked = 0; exp_timeout = 0;
      end else if (!active) begin
         active = 1; have_ref = 0; ref_e = e + 1;
      end else begin
         rise = (c >= 3) && sig_h[c-2] && !sig_h[c-3];
         if (rise) begin
            if (have_ref) begin
               h = 0;
               for (int k = ref_e - 3; k <= c - 3; k++) h += int'(sig_h[k]);
               run = (run > 0 && (e - ref_e) == last_p) ? run + 1 : 1;
               last_p = e - ref_e;
               exp_mv = 1;
               exp_period = e - ref_e;
               exp_high = h;
               exp_locked = (run >= LOCK_N);
            end
            have_ref = 1;
            ref_e = e;
         end else if (e - ref_e == MAXC) begin
            exp_timeout = 1; exp_locked = 0; run = 0;
            have_ref = 0; ref_e = e + 1;
         end
      end
   endtask

   task automatic step(input bit s, input bit e, input bit r);
      if (cyc >= HIST - 1) begin
         $display("FAIL cycle_budget cycle=%0d", cyc);
         $fatal(1);
      end
      @(posedge clk);
      #1;
      i_sig_in = s; i_en = e; i_rst = r;
      sig_h[cyc] = s; en_h[cyc] = e;
      @(negedge clk);
      chk("meas_valid", o_meas_valid, exp_mv);
      chk("period",     o_period,     exp_period);
      chk("high_time",  o_high_time,  exp_high);
      chk("locked",     o_locked,     exp_locked);
      chk("timeout",    o_timeout,    exp_timeout);
      model_edge(cyc, r);
      cyc++;
   endtask

   task automatic wave(input int hi, input int lo, input int n, input bit e);
      for (int i = 0; i < n; i++) begin
         repeat (hi) step(1'b1, e, 1'b0);
         repeat (lo) step(1'b0, e, 1'b0);
      end
   endtask

   initial begin
      int p, h, n, caps;

      // Reset with sig toggling, then idle with en low.
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      wave(5, 5, 2, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);

      // Enable, period 10 until locked, then 3/4, back to 10, then 6/6.
      repeat (3) step(1'b0, 1'b1, 1'b0);
      wave(5, 5, 6, 1'b1);
      wave(3, 4, 6, 1'b1);
      wave(5, 5, 6, 1'b1);
      wave(6, 6, 6, 1'b1);

      // Minimum period.
      wave(1, 1, 6, 1'b1);

      // Lock then starve to timeout; en pulse low clears it; edges exactly 63 apart.
      wave(5, 5, 5, 1'b1);
      repeat (70) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      wave(20, 43, 3, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);

      // Drop en mid-period, re-enable, then a clean run.
      wave(4, 4, 5, 1'b1);
      repeat (3) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b1, 1'b0);
      wave(4, 4, 6, 1'b1);

      // Randomized synchronous waveforms.
      for (int i = 0; i < 14; i++) begin
         p = $urandom_range(30, 2);
         h = $urandom_range(p - 1, 1);
         n = $urandom_range(6, 1);
         wave(h, p - h, n, 1'b1);
      end
      repeat (6) step(1'b0, 1'b0, 1'b0);

      // Asynchronous strobe: 32 ns high, 42 ns low against a 10 ns clock.
      caps = 0;
      fork
         begin
            @(posedge clk);
            #7;
            for (int k = 0; k < 80; k++) begin
               i_sig_in = 1'b1;
               #32;
               i_sig_in = 1'b0;
               #42;
            end
         end
      join_none
      @(posedge clk);
      #1 i_en = 1'b1;
      repeat (640) begin
         @(negedge clk);
         if (o_meas_valid) begin
            caps++;
            total++;
            assert (o_period >= 7 && o_period <= 8) else begin
               bad++;
               $error("FAIL async_period got=%0d exp=7..8", o_period);
            end
            total++;
            assert (o_high_time >= 3 && o_high_time <= 4) else begin
               bad++;
               $error("FAIL async_high got=%0d exp=3..4", o_high_time);
            end
         end
      end
      total++;
      assert (caps >= 60) else begin
         bad++;
         $error("FAIL async_captures got=%0d exp>=60", caps);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
